// File: rtl/lr_shift_pkg.sv
// rtl/lr_shift_pkg.sv - shared state encoding, direction constants and clog2 for the shift stage
package lr_shift_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   localparam logic [1:0] LRS_EMPTY = 2'd0;
   localparam logic [1:0] LRS_ONE   = 2'd1;
   localparam logic [1:0] LRS_FULL  = 2'd2;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY = LRS_EMPTY,
      ST_ONE   = LRS_ONE,
      ST_FULL  = LRS_FULL
   } lrs_state_e;

endpackage

// File: rtl/lr_shift_core.sv
// rtl/lr_shift_core.sv - combinational logical left/right shift, with rotate under LR_SHIFT_ROTATE_EN
module lr_shift_core
   import lr_shift_pkg::*;
#(
   parameter int width = 8
) (
   input  logic [width-1:0]        iBits,
   input  logic [clog2(width)-1:0] shift,
   input  logic                    dir,
`ifdef LR_SHIFT_ROTATE_EN
   input  logic                    rot,
`endif
   output logic [width-1:0]        result
);

`ifdef LR_SHIFT_ROTATE_EN
   logic [2*width-1:0] dbl_l;
   logic [2*width-1:0] dbl_r;
`endif

   always_comb begin
      result = (dir == DIR_RIGHT) ? (iBits >> shift) : (iBits << shift);
`ifdef LR_SHIFT_ROTATE_EN
      // Shifting a doubled copy brings the wrapped bits in from the other half.
      dbl_l = {iBits, iBits} << shift;
      dbl_r = {iBits, iBits} >> shift;
      if (rot) begin
         result = (dir == DIR_LEFT) ? dbl_l[2*width-1:width] : dbl_r[width-1:0];
      end
`endif
   end

endmodule

// File: rtl/lr_shift_stage.sv
// rtl/lr_shift_stage.sv - registered shift stage with one-entry skid buffer; rot port under LR_SHIFT_ROTATE_EN
module lr_shift_stage
   import lr_shift_pkg::*;
#(
   parameter int width = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic [width-1:0]        iBits,
   input  logic [clog2(width)-1:0] shift,
   input  logic                    dir,
`ifdef LR_SHIFT_ROTATE_EN
   input  logic                    rot,
`endif
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic [width-1:0]        oBits,
   output logic [CNT_W-1:0]        done_cnt
);

   lrs_state_e       state_q;
   logic [width-1:0] main_q;
   logic [width-1:0] skid_q;
   logic [width-1:0] shifted;
   logic             o_valid_q;
   logic             i_ready_q;
   logic [CNT_W-1:0] done_cnt_q;
   logic [CNT_W-1:0] done_cnt_d;
   logic             in_xfer;
   logic             out_xfer;

   lr_shift_core #(.width(width)) u_core (
      .iBits  (iBits),
      .shift  (shift),
      .dir    (dir),
`ifdef LR_SHIFT_ROTATE_EN
      .rot    (rot),
`endif
      .result (shifted)
   );

   always_comb begin
      in_xfer    = i_valid && i_ready_q;
      out_xfer   = o_valid_q && o_ready;
      done_cnt_d = out_xfer ? done_cnt_q + CNT_W'(1) : done_cnt_q;
   end

   // i_ready is registered so it never depends combinationally on o_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         o_valid_q  <= 1'b0;
         i_ready_q  <= 1'b1;
         done_cnt_q <= '0;
      end else begin
         done_cnt_q <= done_cnt_d;
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_q    <= shifted;
                  o_valid_q <= 1'b1;
                  state_q   <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_q <= shifted;
               end else if (in_xfer) begin
                  skid_q    <= shifted;
                  i_ready_q <= 1'b0;
                  state_q   <= ST_FULL;
               end else if (out_xfer) begin
                  o_valid_q <= 1'b0;
                  state_q   <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  main_q    <= skid_q;
                  i_ready_q <= 1'b1;
                  state_q   <= ST_ONE;
               end
            end
            default: begin
               state_q   <= ST_EMPTY;
               o_valid_q <= 1'b0;
               i_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign i_ready  = i_ready_q;
   assign o_valid  = o_valid_q;
   assign oBits    = main_q;
   assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_lr_shift_stage.sv
// tb/tb_lr_shift_stage.sv - directed and random checks of lr_shift_stage against an occupancy/arithmetic model
module tb_lr_shift_stage;

   localparam int W  = 8;
   localparam int CW = 4;
`ifdef LR_SHIFT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready;
   logic [W-1:0]  iBits = '0;
   logic [2:0]    shift = '0;
   logic          dir = 1'b0;
   logic          rot = 1'b0;
   logic          o_valid;
   logic          o_ready = 1'b0;
   logic [W-1:0]  oBits;
   logic [CW-1:0] done_cnt;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   int exp_cnt = 0;

   lr_shift_stage #(.width(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .iBits    (iBits),
      .shift    (shift),
      .dir      (dir),
`ifdef LR_SHIFT_ROTATE_EN
      .rot      (rot),
`endif
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .oBits    (oBits),
      .done_cnt (done_cnt)
   );

   always #5 clk = ~clk;

   // Shift as multiply/divide by 2**s modulo 256; rotate adds back the bits that fall off.
   function automatic logic [W-1:0] model_res(input logic [W-1:0] x, input int s, input bit d, input bit r);
      int v;
      int p;
      v = int'(x);
      p = 1 << s;
      if (r) begin
         if (d) return W'((v / p) + ((v * (256 / p)) % 256));
         else   return W'(((v * p) % 256) + (v / (256 / p)));
      end
      if (d) return W'(v / p);
      return W'((v * p) % 256);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: a FIFO of at most two results; occupancy defines valid/ready.
   always @(negedge clk) begin
      bit can_in;
      bit do_out;
      if (!rst_n) begin
         exp_q.delete();
         exp_cnt = 0;
      end else begin
         check("mon_o_valid", o_valid, exp_q.size() > 0);
         check("mon_i_ready", i_ready, exp_q.size() < 2);
         check("mon_done_cnt", done_cnt, exp_cnt % (1 << CW));
         if (exp_q.size() > 0) check("mon_oBits", oBits, exp_q[0]);
         can_in = exp_q.size() < 2;
         do_out = (exp_q.size() > 0) && o_ready;
         if (do_out) begin
            void'(exp_q.pop_front());
            exp_cnt++;
         end
         if (i_valid && can_in) exp_q.push_back(model_res(iBits, int'(shift), dir, ROT_EN && rot));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] x, input int s, input logic d, input logic r);
      bit acc;
      int n;
      iBits   = x;
      shift   = s[2:0];
      dir     = d;
      rot     = r;
      i_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = i_ready;
         tick();
         n++;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int sent;
      int n;

      tick();
      check("rst_o_valid", o_valid, 0);
      check("rst_oBits", oBits, 0);
      check("rst_i_ready", i_ready, 1);
      check("rst_done_cnt", done_cnt, 0);
      rst_n = 1'b1;
      tick();

      o_ready = 1'b1;
      send(8'b1011_0001, 3, 1'b1, 1'b0);
      check("t1_o_valid", o_valid, 1);
      check("t1_oBits", oBits, 8'b0001_0110);
      tick();
      check("t1_done_cnt", done_cnt, 1);
      check("t1_drained", o_valid, 0);

      send(8'b1011_0001, 3, 1'b0, 1'b0);
      check("t2_left3", oBits, 8'b1000_1000);
      tick();
      send(8'b1011_0001, 0, 1'b1, 1'b0);
      check("t2_shift0", oBits, 8'b1011_0001);
      tick();
      send(8'hFF, 7, 1'b1, 1'b0);
      check("t2_right7", oBits, 8'h01);
      tick();
      send(8'hFF, 7, 1'b0, 1'b0);
      check("t2_left7", oBits, 8'h80);
      tick();

      o_ready = 1'b0;
      send(8'h80, 1, 1'b1, 1'b0);
      check("t3_a_oBits", oBits, 8'h40);
      check("t3_a_i_ready", i_ready, 1);
      send(8'h40, 1, 1'b1, 1'b0);
      check("t3_full_i_ready", i_ready, 0);
      check("t3_full_oBits", oBits, 8'h40);
      iBits = 8'h10; shift = 3'd1; dir = 1'b1; rot = 1'b0; i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_hold_i_ready", i_ready, 0);
         check("t3_hold_oBits", oBits, 8'h40);
      end
      o_ready = 1'b1;
      tick();
      check("t3_rel_oBits", oBits, 8'h20);
      check("t3_rel_i_ready", i_ready, 1);
      tick();
      check("t3_c_oBits", oBits, 8'h08);
      i_valid = 1'b0;
      tick();
      check("t3_empty", o_valid, 0);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sent = 0;
      n = 0;
      while ((sent < 100 || o_valid) && n < 3000) begin
         if (!i_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
            iBits   = W'($urandom_range(0, 255));
            shift   = 3'($urandom_range(0, 7));
            dir     = 1'($urandom_range(0, 1));
            rot     = 1'($urandom_range(0, 1));
            i_valid = 1'b1;
         end
         o_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = i_valid && i_ready;
         tick();
         if (acc) begin
            sent++;
            i_valid = 1'b0;
         end
         n++;
      end
      check("t4_budget", n < 3000, 1);
      check("t4_sent", sent, 100);
      check("t4_done_cnt", done_cnt, 4);

      o_ready = 1'b0;
      send(8'h80, 1, 1'b1, 1'b0);
      send(8'h40, 1, 1'b1, 1'b0);
      check("t5_full", i_ready, 0);
      rst_n = 1'b0;
      #1;
      check("t5_o_valid", o_valid, 0);
      check("t5_oBits", oBits, 0);
      check("t5_done_cnt", done_cnt, 0);
      check("t5_i_ready", i_ready, 1);
      tick();
      rst_n = 1'b1;
      o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t5_no_stale", o_valid, 0);
      end
      check("t5_ready_after", i_ready, 1);

      for (int k = 0; k < 17; k++) send(W'(k + 1), 0, 1'b0, 1'b0);
      tick();
      check("t6_wrap_done_cnt", done_cnt, 1);

`ifdef LR_SHIFT_ROTATE_EN
      send(8'b1000_0001, 1, 1'b1, 1'b1);
      check("t6_rot_right", oBits, 8'b1100_0000);
      tick();
      send(8'b1000_0001, 1, 1'b0, 1'b1);
      check("t6_rot_left", oBits, 8'b0000_0011);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lr_shift_stage.md
# lr_shift_stage

Registered, handshaked left/right shift stage with a one-entry skid buffer. It accepts a bit vector, a shift amount and a direction on a valid/ready input and presents the shifted result on a valid/ready output one cycle later. It sits between the request producer and the downstream consumer of shifted words, and wraps the combinational shift in a backpressure-safe pipeline stage.

## Interface
- `width`, default 8: bit width of `iBits`/`oBits`. Must be ≥2.
- `CNT_W`, default 16: width of the completed-transfer counter.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low. Deassertion is synchronous to `clk`. One clock; the reset polarity and synchronicity are fixed.
- `i_valid`  in  1: an input request is present.
- `i_ready`  out  1: the stage can accept a request.
- `iBits`  in  `width`: input bits.
- `shift`  in  `clog2(width)`: requested shift amount.
- `dir`  in  1: 0 = logical left, 1 = logical right.
- `rot`  in  1: rotate instead of shift. Present only with `LR_SHIFT_ROTATE_EN`.
- `o_valid`  out  1: a result is present.
- `o_ready`  in  1: the consumer accepts the result.
- `oBits`  out  `width`: shifted result.
- `done_cnt`  out  `CNT_W`: number of output transfers, wrapping.

## Operation
- Input transfer occurs when `i_valid && i_ready`. Output transfer occurs when `o_valid && o_ready`.
- Shift is computed combinationally on the input side and the result is registered. Fill bits are 0.
- `shift` = 0 passes the input through unchanged. `shift` = `width`-1 leaves only 1 source bit.
- The shift amount is unsigned and never exceeds `width`-1. No saturation logic is needed.
- Storage is a main output register plus one skid register.
- States:
  - EMPTY: `o_valid`=0, `i_ready`=1.
  - ONE: main register full, `o_valid`=1, `i_ready`=1.
  - FULL: main and skid registers full, `o_valid`=1, `i_ready`=0.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in, no out → FULL; the new result goes to skid.
  - ONE + in + out → ONE; main takes the new result.
  - ONE + out only → EMPTY.
  - FULL + out → ONE; main takes skid.
  - FULL never accepts input.
- `i_ready` is a registered signal (`!FULL`) and has no combinational path from `o_ready`.
- `done_cnt` increments on every output transfer and wraps from 2^`CNT_W`-1 to 0.
- `o_valid` never drops without a transfer. `oBits` is stable while `o_valid && !o_ready`.

## Timing
- Reset values: `o_valid`=0, `oBits`=0, `i_ready`=1, `done_cnt`=0. The state goes to EMPTY and the skid register is cleared.
- Latency: a request accepted at edge N gives `o_valid`=1 with its result after edge N.
- Throughput: 1 transfer/cycle while `o_ready`=1.
- `i_ready` falls the cycle after the skid register fills. It rises the cycle after FULL drains to ONE.
- Reset asserted mid-operation discards both registered results immediately. Outputs go to their reset values asynchronously.
- Simultaneous in and out in ONE keeps `o_valid` high with no bubble.

## Configuration
- `LR_SHIFT_ROTATE_EN` defined:
  - the `rot` port exists.
  - With `rot`=1, `dir`=0 rotates left and `dir`=1 rotates right. Vacated bits are filled from the opposite end.
  - `rot`=0 behaves exactly as below.
- Undefined: `rot` is absent and only logical shifts with zero fill are implemented. Area and ports otherwise remain the same.

## Structure
- Shared package holds:
  - `clog2` function.
  - State encoding constants `LRS_EMPTY`/`LRS_ONE`/`LRS_FULL` (2-bit).
  - `DIR_LEFT`=0 and `DIR_RIGHT`=1.
- One sub-module: `lr_shift_core`. It is purely combinational (`iBits`, `shift`, `dir`, optional `rot` → result). Instantiate it once on the input side.
- Skid and handshake logic stay in `lr_shift_stage`.

## Test plan
All scenarios use `width`=8.
1. Reset, then `iBits`=8'b1011_0001, `shift`=3, `dir`=1, `o_ready`=1 → next cycle `o_valid`=1, `oBits`=8'b0001_0110, `done_cnt`=1.
2. Same input with `dir`=0 → `oBits`=8'b1000_1000. Also `shift`=0 → `oBits`=`iBits`. Also `shift`=7, `dir`=1, `iBits`=8'hFF → `oBits`=8'h01.
3. Backpressure:
   - Setup: `o_ready`=0; send A=8'h80 (right 1) and B=8'h40 (right 1) back-to-back.
   - While held: `oBits` holds 8'h40, `i_ready`=0 after the second accept, and the third request is not accepted.
   - Release: raise `o_ready` → outputs 8'h40 then 8'h20, with no loss and no duplication.
4. Stream of 100 random requests with `o_ready` toggled randomly → results match the model in order, and `done_cnt`=100.
5. Reset mid-FULL: assert `rst_n`=0 for 1 cycle → immediately `o_valid`=0, `oBits`=0, `done_cnt`=0. After release `i_ready`=1 and the previous data is never emitted.
6. With `LR_SHIFT_ROTATE_EN`: `iBits`=8'b1000_0001, `shift`=1, `rot`=1, `dir`=1 → `oBits`=8'b1100_0000. Same with `dir`=0 → 8'b0000_0011. With `CNT_W`=4, 17 transfers → `done_cnt`=1.
